// File: rtl/ebn.sv
// ---------------------------------------------------------------------------
// ebn -- elastic buffer node: a DEPTH-entry FIFO between a valid/ready
// upstream (t_*) and a valid/ready downstream (i_*) interface.
//
// Optional feature macro: EBN_LEVEL_EN
//   When defined, the occupancy output i_level is added to the port list.
//   When undefined, i_level is absent and the datapath is unchanged.
//
// Ports
//   clk      in   sole clock, rising edge
//   rstf     in   asynchronous active-low reset
//   t_data   in   upstream payload [DWIDTH]
//   t_valid  in   upstream payload valid
//   t_ready  out  buffer can accept a beat (registered)
//   i_data   out  head-of-buffer payload (registered storage)
//   i_valid  out  head-of-buffer valid (registered state)
//   i_ready  in   downstream accepts head
//   i_level  out  occupancy 0..DEPTH [$clog2(DEPTH+1)] (EBN_LEVEL_EN only)
// ---------------------------------------------------------------------------
module ebn #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rstf,
   input  logic [DWIDTH-1:0]          t_data,
   input  logic                       t_valid,
   output logic                       t_ready,
   output logic [DWIDTH-1:0]          i_data,
   output logic                       i_valid,
   input  logic                       i_ready
`ifdef EBN_LEVEL_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] i_level
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              ready_r;
   logic              push;
   logic              pop;

   // Modulo-DEPTH increment; works for any DEPTH, not only powers of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         next_ptr = '0;
      end else begin
         next_ptr = p + 1'b1;
      end
   endfunction

   // Handshakes only ever see registered ready/valid, so there is no
   // combinational path from i_ready or t_valid back to t_ready.
   assign push = t_valid & ready_r;
   assign pop  = i_valid & i_ready;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   // t_ready is held in its own flop rather than decoded from count so it
   // reads 0 while reset is asserted and rises at the first edge after.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ready_r <= 1'b0;
      end else begin
         count   <= count_next;
         ready_r <= (count_next < FULL_CNT);
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
      end
   end

   // Storage is cleared on reset so an empty buffer presents i_data = 0.
   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= t_data;
      end
   end

   assign t_ready = ready_r;
   assign i_valid = (count != '0);
   assign i_data  = mem[rd_ptr];

`ifdef EBN_LEVEL_EN
   assign i_level = count;
`endif

endmodule

// File: tb/tb_ebn.sv
`timescale 1ns/1ps
module tb_ebn;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rstf;
   logic       tvalid [N];
   logic [7:0] tdata  [N];
   logic       tready [N];
   logic [7:0] idata  [N];
   logic       ivalid [N];
   logic       iready [N];
`ifdef EBN_LEVEL_EN
   int unsigned lvl [N];
`endif

   int compared   = 0;
   int mismatched = 0;
   int pops_seen  = 0;
   logic [7:0] mq[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
`ifdef EBN_LEVEL_EN
      logic [$clog2(D+1)-1:0] lv;
      assign lvl[g] = 32'(lv);
`endif
      ebn #(.DWIDTH(8), .DEPTH(D)) u_dut (
         .clk     (clk),
         .rstf    (rstf),
         .t_data  (tdata[g]),
         .t_valid (tvalid[g]),
         .t_ready (tready[g]),
         .i_data  (idata[g]),
         .i_valid (ivalid[g]),
         .i_ready (iready[g])
`ifdef EBN_LEVEL_EN
         ,
         .i_level (lv)
`endif
      );
   end

   function automatic int depth_of(input int k);
      case (k)
         0: depth_of = 4;
         1: depth_of = 2;
         2: depth_of = 3;
         default: depth_of = 1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle on DUT k: drive inputs after a falling edge, compare against the
   // queue model, advance the model by the handshake rules, move to next negedge.
   task automatic step(input int k, input logic tv, input logic [7:0] td, input logic ir);
      logic exp_ready, exp_valid;
      tvalid[k] = tv;
      tdata[k]  = td;
      iready[k] = ir;
      #1;
      exp_ready = (mq.size() < depth_of(k));
      exp_valid = (mq.size() != 0);
      check($sformatf("t_ready dut%0d", k), 32'(tready[k]), 32'(exp_ready));
      check($sformatf("i_valid dut%0d", k), 32'(ivalid[k]), 32'(exp_valid));
      if (exp_valid) check($sformatf("i_data dut%0d", k), 32'(idata[k]), 32'(mq[0]));
`ifdef EBN_LEVEL_EN
      check($sformatf("i_level dut%0d", k), lvl[k], 32'(mq.size()));
`endif
      if (ivalid[k] && ir) pops_seen++;
      if (exp_valid && ir) void'(mq.pop_front());
      if (tv && exp_ready) mq.push_back(td);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < N; k++) begin
         tvalid[k] = 1'b0;
         tdata[k]  = 8'h00;
         iready[k] = 1'b0;
      end
   endtask

   task automatic do_reset(input bit check_state);
      idle_inputs();
      mq.delete();
      rstf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (check_state) begin
         for (int k = 0; k < N; k++) begin
            check($sformatf("reset t_ready dut%0d", k), 32'(tready[k]), 32'd0);
            check($sformatf("reset i_valid dut%0d", k), 32'(ivalid[k]), 32'd0);
            check($sformatf("reset i_data dut%0d", k), 32'(idata[k]), 32'd0);
         end
      end
      rstf = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic       tv;
      logic [7:0] td;
      logic       ir;
      logic       er;
      logic       ev;
      logic [7:0] ed;
      logic       cd;
      int         el;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1};
      tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 2};
      tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 3};
      tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 4};
      tbl[5] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 4};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 3};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 2};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};

      rstf = 1'b0;
      idle_inputs();
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("por t_ready dut%0d", k), 32'(tready[k]), 32'd0);
         check($sformatf("por i_valid dut%0d", k), 32'(ivalid[k]), 32'd0);
      end
      @(negedge clk);
      do_reset(1'b1);

      // Fill DEPTH=4 to full with downstream stalled, full-with-both, drain.
      for (int i = 0; i < 10; i++) begin
         tvalid[0] = tbl[i].tv;
         tdata[0]  = tbl[i].td;
         iready[0] = tbl[i].ir;
         #1;
         check($sformatf("tbl%0d t_ready", i), 32'(tready[0]), 32'(tbl[i].er));
         check($sformatf("tbl%0d i_valid", i), 32'(ivalid[0]), 32'(tbl[i].ev));
         if (tbl[i].cd) check($sformatf("tbl%0d i_data", i), 32'(idata[0]), 32'(tbl[i].ed));
`ifdef EBN_LEVEL_EN
         check($sformatf("tbl%0d i_level", i), lvl[0], 32'(tbl[i].el));
`endif
         @(posedge clk);
         @(negedge clk);
      end
      idle_inputs();

      // DEPTH=2 streaming 1..100 at full rate.
      do_reset(1'b0);
      pops_seen = 0;
      for (int i = 1; i <= 100; i++) step(1, 1'b1, 8'(i), 1'b1);
      step(1, 1'b0, 8'h00, 1'b1);
      check("depth2 beats out", 32'(pops_seen), 32'd100);
      check("depth2 drained", 32'(ivalid[1]), 32'd0);

      // Mid-operation reset while holding two beats.
      do_reset(1'b0);
      step(1, 1'b1, 8'hA1, 1'b0);
      step(1, 1'b1, 8'hA2, 1'b0);
      tvalid[1] = 1'b0;
      #2;
      rstf = 1'b0;
      #1;
      check("midrst i_valid", 32'(ivalid[1]), 32'd0);
      check("midrst i_data", 32'(idata[1]), 32'd0);
      check("midrst t_ready", 32'(tready[1]), 32'd0);
      mq.delete();
      @(posedge clk);
      @(negedge clk);
      rstf = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("postrst i_data", 32'(idata[1]), 32'd0);
      for (int i = 0; i < 3; i++) step(1, 1'b0, 8'h00, 1'b1);
      step(1, 1'b1, 8'h5A, 1'b0);
      step(1, 1'b0, 8'h00, 1'b1);
      step(1, 1'b0, 8'h00, 1'b1);

      // DEPTH=1: ready must not follow i_ready; throughput one beat per two cycles.
      do_reset(1'b0);
      step(3, 1'b1, 8'h01, 1'b0);
      tvalid[3] = 1'b1;
      iready[3] = 1'b1;
      #1;
      check("depth1 t_ready ir=1", 32'(tready[3]), 32'd0);
      iready[3] = 1'b0;
      #1;
      check("depth1 t_ready ir=0", 32'(tready[3]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      pops_seen = 0;
      for (int i = 0; i < 40; i++) step(3, 1'b1, 8'(8'h10 + i), 1'b1);
      check("depth1 beats in 40 cycles", 32'(pops_seen), 32'd20);

      // Random traffic on every depth, including the DEPTH=3 wrap case.
      for (int j = 0; j < N; j++) begin
         int k;
         k = (j + 2) % N;
         do_reset(1'b0);
         for (int i = 0; i < 150; i++)
            step(k, ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1));
         for (int i = 0; i <= depth_of(k); i++) step(k, 1'b0, 8'h00, 1'b1);
         check($sformatf("random drained dut%0d", k), 32'(ivalid[k]), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ebn.md
EBN -- requirements
Module: ebn

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of buffer entries (>=1, need not be a power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstf  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port t_data  input  DWIDTH  upstream payload.
REQ-006 SHALL have port t_valid  input  1  upstream payload valid.
REQ-007 SHALL have port t_ready  output  1  buffer can accept a beat.
REQ-008 SHALL have port i_data  output  DWIDTH  head-of-buffer payload.
REQ-009 SHALL have port i_valid  output  1  head-of-buffer valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts head.
REQ-011 SHALL have port i_level  output  $clog2(DEPTH+1)  occupancy; present only when EBN_LEVEL_EN is defined.

Function
REQ-012 SHALL define push = t_valid & t_ready and pop = i_valid & i_ready, both evaluated in the same cycle.
REQ-013 SHALL store the pushed t_data at the write pointer and deliver beats in strict FIFO order, no loss, no duplication.
REQ-014 SHALL drive t_ready = (count < DEPTH) from registered state only; no combinational path from i_ready or t_valid to t_ready.
REQ-015 SHALL drive i_valid = (count != 0) and i_data = entry at the read pointer, both from registered state only.
REQ-016 SHALL have latency of exactly 1 cycle: a beat pushed into an empty buffer at edge N is presented with i_valid=1 in the cycle after edge N.
REQ-017 SHALL update the count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-018 SHALL accept a push in the same cycle as a pop when the buffer is neither full nor empty, with both taking effect at the same edge.
REQ-019 SHALL deassert t_ready when full, even if i_ready=1 in that cycle; a full buffer with i_ready=1 pops only.
REQ-020 SHALL sustain one beat per cycle with continuous t_valid and i_ready when DEPTH>=2; DEPTH=1 SHALL give at most one beat every 2 cycles.
REQ-021 SHALL advance each pointer from DEPTH-1 to 0 (modulo DEPTH), independently of power-of-two sizing.
REQ-022 SHALL hold i_data stable while i_valid=1 and i_ready=0.
REQ-023 SHALL ignore t_data while t_valid=0 and SHALL ignore i_ready while i_valid=0.

Reset
REQ-024 SHALL, on rstf low, immediately set count=0, read pointer=0, write pointer=0, i_valid=0, t_ready=0 during reset, and i_data=0.
REQ-025 SHALL clear all storage entries to 0 on reset, so i_data reads 0 when empty after reset.
REQ-026 SHALL assert t_ready=1 in the first cycle after rstf deasserts, with the buffer empty.
REQ-027 SHALL discard all buffered beats when reset is asserted mid-operation, with no partial beat emitted afterwards.

Configuration
REQ-028 SHALL, with EBN_LEVEL_EN defined, drive i_level = count (registered, 0..DEPTH, reset 0); without it, omit port i_level entirely with identical datapath behaviour.

Verification
REQ-029 SHALL pass this test with DEPTH=4, DWIDTH=8: push 0x11,0x22,0x33,0x44 with i_ready=0 -> t_ready=0 after the 4th push, i_level=4; then i_ready=1 -> 0x11..0x44 out in order, one per cycle.
REQ-030 SHALL pass this test with DEPTH=2: continuous t_valid, i_ready=1, data 1..100 -> 100 beats out in order, one per cycle, first beat 1 cycle after first push.
REQ-031 SHALL pass this test with DEPTH=3: run 10 beats with random t_valid and i_ready -> pointers wrap past 2->0 with no loss and order preserved.
REQ-032 SHALL pass this test, full buffer with t_valid=1 and i_ready=1 -> pop only, count drops to DEPTH-1, and t_ready=1 in the next cycle.
REQ-033 SHALL pass this test: drop rstf while holding 2 beats -> i_valid=0 and i_data=0 immediately; after release, t_ready=1 and no stale beat appears.
REQ-034 SHALL pass this test with DEPTH=1: continuous traffic -> throughput is 1 beat per 2 cycles and t_ready never depends combinationally on i_ready.
